// File: rtl/frogger_pkg.sv
// Shared constants and types for the frog turn sequencer: FSM state encoding,
// default home-row geometry and per-attempt frame budgets.
package frogger_pkg;

    localparam int DEFAULT_HOME_Y         = 40;
    localparam int DEFAULT_HOME_X0        = 120;
    localparam int DEFAULT_HOME_X1        = 280;
    localparam int DEFAULT_HOME_X2        = 480;
    localparam int DEFAULT_TURN_FRAMES    = 600;
    localparam int DEFAULT_RESPAWN_FRAMES = 30;

    localparam int          NUM_SLOTS   = 3;
    localparam logic [1:0]  START_LIVES = 2'd3;
    localparam logic [1:0]  LAST_FROG   = 2'd2;
    localparam int          TIMER_W     = 10;

    typedef enum logic [2:0] {
        SPAWN,
        PLAY,
        HOME,
        DIED,
        WAIT,
        WIN,
        LOSE
    } frog_state_t;

    function automatic logic [NUM_SLOTS-1:0] slot_bit(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable frame down-counter that saturates at zero; used for both the
// per-attempt turn timer and the respawn delay.
module frame_down_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/frog_turn_sequencer.sv
// Turn sequencer for a three-frog game: spawns frogs, times each attempt,
// records home arrivals and deaths, and decides win/lose.
module frog_turn_sequencer
    import frogger_pkg::*;
#(
    parameter int HOME_Y         = DEFAULT_HOME_Y,
    parameter int HOME_X0        = DEFAULT_HOME_X0,
    parameter int HOME_X1        = DEFAULT_HOME_X1,
    parameter int HOME_X2        = DEFAULT_HOME_X2,
    parameter int TURN_FRAMES    = DEFAULT_TURN_FRAMES,
    parameter int RESPAWN_FRAMES = DEFAULT_RESPAWN_FRAMES
) (
    input  logic                 frame_clk,
    input  logic                 game_restart,
    input  logic [10:0]          frog_x,
    input  logic [10:0]          frog_y,
    input  logic                 dead_frog,
    output logic [1:0]           active_frog,
    output logic                 spawn_frog,
    output logic                 frog_enable,
    output logic [NUM_SLOTS-1:0] home_slots,
    output logic [1:0]           frog_lives,
    output logic [TIMER_W-1:0]   turn_timer,
    output logic                 win_game,
    output logic                 lose_game
);

    frog_state_t state;

    logic                 home_row;
    logic [NUM_SLOTS-1:0] slot_hit;
    logic                 arrive;
    logic                 death;
    logic [1:0]           hit_slot;
    logic [1:0]           matched_slot;
    logic [NUM_SLOTS-1:0] slots_after_home;
    logic [1:0]           lives_after_death;

    logic                 turn_load;
    logic                 turn_dec;
    logic                 turn_zero;
    logic                 respawn_load;
    logic                 respawn_dec;
    logic [TIMER_W-1:0]   respawn_value;
    logic [TIMER_W-1:0]   respawn_count;
    logic                 respawn_zero;

    // Reaching the home row anywhere other than a free slot is fatal, and
    // death always outranks a simultaneous home arrival.
    always_comb begin
        home_row    = (frog_y == 11'(HOME_Y));
        slot_hit[0] = home_row && (frog_x == 11'(HOME_X0)) && !home_slots[0];
        slot_hit[1] = home_row && (frog_x == 11'(HOME_X1)) && !home_slots[1];
        slot_hit[2] = home_row && (frog_x == 11'(HOME_X2)) && !home_slots[2];
        arrive      = |slot_hit;
        death       = dead_frog || turn_zero || (home_row && !arrive);

        hit_slot = 2'd2;
        if (slot_hit[0]) begin
            hit_slot = 2'd0;
        end else if (slot_hit[1]) begin
            hit_slot = 2'd1;
        end

        slots_after_home  = home_slots | slot_bit(matched_slot);
        lives_after_death = (frog_lives == 2'd0) ? 2'd0 : frog_lives - 2'd1;
    end

    assign turn_load     = game_restart || (state == SPAWN);
    assign turn_dec      = (state == PLAY);
    assign respawn_load  = game_restart || (state == HOME) || (state == DIED);
    assign respawn_value = game_restart ? '0 : TIMER_W'(RESPAWN_FRAMES - 1);
    assign respawn_dec   = (state == WAIT) && (respawn_count != '0);

    frame_down_counter #(
        .WIDTH      (TIMER_W)
    ) u_turn_counter (
        .clk        (frame_clk),
        .load       (turn_load),
        .load_value (TIMER_W'(TURN_FRAMES)),
        .dec        (turn_dec),
        .count      (turn_timer),
        .zero       (turn_zero)
    );

    // Loaded with RESPAWN_FRAMES-1 so WAIT occupies exactly RESPAWN_FRAMES cycles.
    frame_down_counter #(
        .WIDTH      (TIMER_W)
    ) u_respawn_counter (
        .clk        (frame_clk),
        .load       (respawn_load),
        .load_value (respawn_value),
        .dec        (respawn_dec),
        .count      (respawn_count),
        .zero       (respawn_zero)
    );

    // frog_enable, win_game and lose_game track the state being entered, so
    // they are high exactly while the FSM sits in PLAY, WIN or LOSE. The
    // spawn pulse lands on the first PLAY cycle of each attempt.
    always_ff @(posedge frame_clk) begin
        if (game_restart) begin
            state        <= SPAWN;
            active_frog  <= 2'd0;
            spawn_frog   <= 1'b0;
            frog_enable  <= 1'b0;
            home_slots   <= '0;
            frog_lives   <= START_LIVES;
            win_game     <= 1'b0;
            lose_game    <= 1'b0;
            matched_slot <= 2'd0;
        end else begin
            spawn_frog <= 1'b0;
            unique case (state)
                SPAWN: begin
                    state       <= PLAY;
                    spawn_frog  <= 1'b1;
                    frog_enable <= 1'b1;
                end
                PLAY: begin
                    if (death) begin
                        state       <= DIED;
                        frog_enable <= 1'b0;
                    end else if (arrive) begin
                        state        <= HOME;
                        matched_slot <= hit_slot;
                        frog_enable  <= 1'b0;
                    end
                end
                HOME: begin
                    home_slots <= slots_after_home;
                    if (&slots_after_home) begin
                        state    <= WIN;
                        win_game <= 1'b1;
                    end else begin
                        state <= WAIT;
                        if (active_frog != LAST_FROG) begin
                            active_frog <= active_frog + 2'd1;
                        end
                    end
                end
                DIED: begin
                    frog_lives <= lives_after_death;
                    if (lives_after_death == 2'd0) begin
                        state     <= LOSE;
                        lose_game <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (respawn_zero) begin
                        state <= SPAWN;
                    end
                end
                WIN, LOSE: begin
                    frog_enable <= 1'b0;
                end
                default: begin
                    state       <= SPAWN;
                    frog_enable <= 1'b0;
                end
            endcase
        end
    end

    a_frog_index: assert property (@(posedge frame_clk) disable iff (game_restart)
        active_frog <= LAST_FROG);
    a_terminal_exclusive: assert property (@(posedge frame_clk) disable iff (game_restart)
        !(win_game && lose_game));
    a_no_move_when_over: assert property (@(posedge frame_clk) disable iff (game_restart)
        (win_game || lose_game) |-> !frog_enable);

endmodule

// File: tb/tb_frog_turn_sequencer.sv
// Randomized scoreboard bench: the stimulus side plays whole games against a
// slot/lives model and queues the expected outcome of each attempt.
module tb_frog_turn_sequencer;

    localparam int HOME_Y   = 40;
    localparam int SLOT_X0  = 120;
    localparam int SLOT_X1  = 280;
    localparam int SLOT_X2  = 480;
    localparam int TURN     = 600;
    localparam int RESP     = 30;

    localparam int EV_SPAWN = 0;
    localparam int EV_WIN   = 1;
    localparam int EV_LOSE  = 2;

    localparam int ACT_HOME    = 0;
    localparam int ACT_DEAD    = 1;
    localparam int ACT_WRONG   = 2;
    localparam int ACT_COINC   = 3;
    localparam int ACT_TIMEOUT = 4;

    typedef struct {
        int kind;
        int active;
        int slots;
        int lives;
        int gap;
    } exp_t;

    logic        frame_clk = 1'b0;
    logic        game_restart = 1'b1;
    logic [10:0] frog_x = 11'd0;
    logic [10:0] frog_y = 11'd100;
    logic        dead_frog = 1'b0;
    logic [1:0]  active_frog;
    logic        spawn_frog;
    logic        frog_enable;
    logic [2:0]  home_slots;
    logic [1:0]  frog_lives;
    logic [9:0]  turn_timer;
    logic        win_game;
    logic        lose_game;

    int   tests = 0;
    int   failures = 0;
    bit   in_reset = 1'b1;
    exp_t sb[$];

    int       m_lives;
    int       m_active;
    bit [2:0] m_slots;
    bit       m_over;

    int low_count = 0;
    int play_k = 0;
    bit terminal_seen = 1'b0;

    frog_turn_sequencer #(
        .HOME_Y         (HOME_Y),
        .HOME_X0        (SLOT_X0),
        .HOME_X1        (SLOT_X1),
        .HOME_X2        (SLOT_X2),
        .TURN_FRAMES    (TURN),
        .RESPAWN_FRAMES (RESP)
    ) dut (
        .frame_clk    (frame_clk),
        .game_restart (game_restart),
        .frog_x       (frog_x),
        .frog_y       (frog_y),
        .dead_frog    (dead_frog),
        .active_frog  (active_frog),
        .spawn_frog   (spawn_frog),
        .frog_enable  (frog_enable),
        .home_slots   (home_slots),
        .frog_lives   (frog_lives),
        .turn_timer   (turn_timer),
        .win_game     (win_game),
        .lose_game    (lose_game)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic int slotX(input int k);
        return (k == 0) ? SLOT_X0 : ((k == 1) ? SLOT_X1 : SLOT_X2);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void pushExp(input int kind, input int gap);
        exp_t e;
        e.kind   = kind;
        e.active = m_active;
        e.slots  = int'(m_slots);
        e.lives  = m_lives;
        e.gap    = gap;
        sb.push_back(e);
    endfunction

    // A death costs a life; the same frog retries unless no lives remain.
    function automatic void modelDeath();
        m_lives = m_lives - 1;
        if (m_lives == 0) begin
            m_over = 1'b1;
            pushExp(EV_LOSE, -1);
        end else begin
            pushExp(EV_SPAWN, RESP + 2);
        end
    endfunction

    function automatic void modelHome(input int k);
        m_slots[k] = 1'b1;
        if (m_slots == 3'b111) begin
            m_over = 1'b1;
            pushExp(EV_WIN, -1);
        end else begin
            m_active = m_active + 1;
            pushExp(EV_SPAWN, RESP + 2);
        end
    endfunction

    task automatic neutralInputs();
        frog_x    = 11'($urandom_range(0, 2047));
        frog_y    = 11'(HOME_Y + 1 + $urandom_range(0, 900));
        dead_frog = 1'b0;
    endtask

    function automatic logic [10:0] offSlotX();
        logic [10:0] x;
        do begin
            x = 11'($urandom_range(0, 2047));
        end while (x == 11'(SLOT_X0) || x == 11'(SLOT_X1) || x == 11'(SLOT_X2));
        return x;
    endfunction

    task automatic waitEnable(input logic level, input int budget, input string what);
        int n = 0;
        while (frog_enable !== level && n < budget) begin
            @(negedge frame_clk);
            neutralInputs();
            n++;
        end
        checkOutput(what, frog_enable, level);
    endtask

    task automatic resetGame();
        @(negedge frame_clk);
        in_reset     = 1'b1;
        game_restart = 1'b1;
        sb.delete();
        frog_x    = 11'(SLOT_X0);
        frog_y    = 11'(HOME_Y);
        dead_frog = 1'b1;
        @(negedge frame_clk);
        game_restart = 1'b0;
        neutralInputs();
        checkOutput("reset_active", active_frog, 0);
        checkOutput("reset_spawn", spawn_frog, 0);
        checkOutput("reset_enable", frog_enable, 0);
        checkOutput("reset_slots", home_slots, 0);
        checkOutput("reset_lives", frog_lives, 3);
        checkOutput("reset_timer", turn_timer, TURN);
        checkOutput("reset_win", win_game, 0);
        checkOutput("reset_lose", lose_game, 0);
        m_lives  = 3;
        m_active = 0;
        m_slots  = 3'b000;
        m_over   = 1'b0;
        pushExp(EV_SPAWN, -1);
        in_reset = 1'b0;
    endtask

    // After a terminal outcome the game must ignore any further frog activity.
    task automatic checkTerminalHeld();
        int n = 0;
        while (!(win_game || lose_game) && n < 10) begin
            @(negedge frame_clk);
            n++;
        end
        repeat (5) begin
            @(negedge frame_clk);
            frog_x    = 11'(slotX($urandom_range(0, 2)));
            frog_y    = 11'(HOME_Y);
            dead_frog = 1'b1;
        end
        @(negedge frame_clk);
        neutralInputs();
        checkOutput("held_win", win_game, (m_slots == 3'b111) ? 1 : 0);
        checkOutput("held_lose", lose_game, (m_lives == 0) ? 1 : 0);
        checkOutput("held_enable", frog_enable, 0);
        checkOutput("held_spawn", spawn_frog, 0);
        checkOutput("held_lives", frog_lives, m_lives);
        checkOutput("held_slots", home_slots, m_slots);
        checkOutput("held_active", active_frog, m_active);
    endtask

    task automatic applyStimulus(input int kind, input int slot);
        waitEnable(1'b1, 100, "wait_enable_high");
        repeat ($urandom_range(0, 12)) begin
            @(negedge frame_clk);
            neutralInputs();
        end
        @(negedge frame_clk);
        neutralInputs();
        case (kind)
            ACT_HOME: begin
                frog_x = 11'(slotX(slot));
                frog_y = 11'(HOME_Y);
                modelHome(slot);
            end
            ACT_DEAD: begin
                dead_frog = 1'b1;
                modelDeath();
            end
            ACT_WRONG: begin
                frog_y = 11'(HOME_Y);
                frog_x = (slot >= 0) ? 11'(slotX(slot)) : offSlotX();
                modelDeath();
            end
            ACT_COINC: begin
                frog_x    = 11'(slotX(slot));
                frog_y    = 11'(HOME_Y);
                dead_frog = 1'b1;
                modelDeath();
            end
            default: begin
                modelDeath();
            end
        endcase
        @(negedge frame_clk);
        neutralInputs();
        if (kind == ACT_TIMEOUT) begin
            waitEnable(1'b0, TURN + 20, "timeout_enable_drop");
        end else begin
            checkOutput("enable_drop", frog_enable, 0);
        end
        if (m_over) begin
            checkTerminalHeld();
        end
    endtask

    task automatic randomAction();
        int r;
        int free_list[$];
        int used_list[$];
        for (int k = 0; k < 3; k++) begin
            if (m_slots[k]) used_list.push_back(k);
            else free_list.push_back(k);
        end
        r = $urandom_range(0, 19);
        if (r < 8) begin
            applyStimulus(ACT_HOME, free_list[$urandom_range(0, free_list.size() - 1)]);
        end else if (r < 12) begin
            applyStimulus(ACT_DEAD, 0);
        end else if (r < 15) begin
            if (used_list.size() > 0 && $urandom_range(0, 1) == 1)
                applyStimulus(ACT_WRONG, used_list[$urandom_range(0, used_list.size() - 1)]);
            else
                applyStimulus(ACT_WRONG, -1);
        end else if (r < 19) begin
            applyStimulus(ACT_COINC, free_list[$urandom_range(0, free_list.size() - 1)]);
        end else begin
            applyStimulus(ACT_TIMEOUT, 0);
        end
    endtask

    // Monitor: pops an expectation whenever a spawn pulse or terminal flag
    // appears, and tracks the turn timer against frames spent in play.
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #2;
            if (in_reset) begin
                low_count     = 0;
                play_k        = 0;
                terminal_seen = 1'b0;
                continue;
            end
            if (spawn_frog === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL unexpected_spawn: spawn_frog=1, expected no pending event");
                end else begin
                    e = sb.pop_front();
                    checkOutput("event_kind_spawn", EV_SPAWN, e.kind);
                    checkOutput("spawn_active", active_frog, e.active);
                    checkOutput("spawn_slots", home_slots, e.slots);
                    checkOutput("spawn_lives", frog_lives, e.lives);
                    checkOutput("spawn_enable", frog_enable, 1);
                    if (e.gap >= 0) checkOutput("respawn_gap", low_count, e.gap);
                end
                play_k = 0;
            end
            if (frog_enable === 1'b1) begin
                checkOutput("turn_timer", turn_timer, (TURN - play_k > 0) ? TURN - play_k : 0);
                play_k++;
                low_count = 0;
            end else begin
                low_count++;
            end
            if ((win_game || lose_game) && !terminal_seen) begin
                terminal_seen = 1'b1;
                checkOutput("win_lose_exclusive", win_game & lose_game, 0);
                if (sb.size() == 0) begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL unexpected_terminal: win=%0d lose=%0d, expected no pending event", win_game, lose_game);
                end else begin
                    e = sb.pop_front();
                    checkOutput("event_kind_terminal", win_game ? EV_WIN : EV_LOSE, e.kind);
                    checkOutput("terminal_enable", frog_enable, 0);
                    checkOutput("terminal_active", active_frog, e.active);
                    checkOutput("terminal_slots", home_slots, e.slots);
                    checkOutput("terminal_lives", frog_lives, e.lives);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Game A: home, wrong home on a full slot, death with coincident home, then fill to win.
        resetGame();
        applyStimulus(ACT_HOME, 1);
        applyStimulus(ACT_WRONG, 1);
        applyStimulus(ACT_COINC, 2);
        applyStimulus(ACT_HOME, 0);
        applyStimulus(ACT_HOME, 2);

        // Game B: three deaths lose the game.
        resetGame();
        applyStimulus(ACT_DEAD, 0);
        applyStimulus(ACT_DEAD, 0);
        applyStimulus(ACT_DEAD, 0);

        // Game C: timeout, a home, a death, then restart in the middle of WAIT.
        resetGame();
        applyStimulus(ACT_TIMEOUT, 0);
        applyStimulus(ACT_HOME, 0);
        applyStimulus(ACT_DEAD, 0);
        repeat (10) @(negedge frame_clk);
        checkOutput("midwait_enable", frog_enable, 0);
        resetGame();
        applyStimulus(ACT_HOME, 2);

        repeat (4) begin
            resetGame();
            while (!m_over) randomAction();
        end

        repeat (5) @(negedge frame_clk);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
